uart_rx: RTL

Serial receiver paired with `uart_tx`. It consumes the 8N1-style line that `uart_tx` drives on `ser_out`, oversamples it and reconstructs each frame as a parallel word. Each good frame produces a one-cycle `valid` pulse; each bad stop bit produces a one-cycle `frame_err` pulse. It sits at the receive end of the UART link and feeds parallel consumers such as a FIFO or register file.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_sync.sv | 31 +++
 rtl/uart_rx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and receiver state encoding
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_BIT  = 1'b1;

endpackage

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - two-flop synchronizer for an asynchronous input
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 serial receiver with mid-bit sampling
module uart_rx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ser_in,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic                  frame_err,
  output logic                  busy
);

  import uart_pkg::*;

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  logic                  rx_s;
  logic                  rx_d_q, rx_d_d;
  rx_state_e             state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BW-1:0]         bit_idx_q, bit_idx_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  start_edge;
  logic                  cnt_last;
  logic                  cnt_half;

  uart_sync #(.RESET_VAL(IDLE_BIT)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ser_in),
    .q     (rx_s)
  );

  // Only a high-to-low transition starts a frame, so a held-low line stays quiet.
  assign start_edge = (rx_d_q == IDLE_BIT) && (rx_s == START_BIT);
  assign cnt_last   = (cnt_q == CNT_LAST);
  assign cnt_half   = (cnt_q == CNT_HALF);
  assign rx_d_d     = rx_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_d_q    <= IDLE_BIT;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_d_q    <= rx_d_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start_edge) state_d = START;
      end
      START: begin
        if (cnt_half) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = (rx_s == START_BIT) ? DATA : IDLE;
        end
      end
      DATA: begin
        if (cnt_last) begin
          cnt_d   = '0;
          shreg_d = {rx_s, shreg_q[DATA_WIDTH-1:1]};
          if (bit_idx_q == BIT_LAST) state_d = STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dout_d  = dout_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (state_q == STOP && cnt_last) begin
      if (rx_s == STOP_BIT) begin
        valid_d = 1'b1;
        dout_d  = shreg_q;
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  assign dout      = dout_q;
  assign valid     = valid_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != IDLE);

endmodule
